cdc_handshake_arbiter: RTL and testbench
========================================

# cdc_handshake_arbiter

Source-domain controller that shares one 4-phase req/ack clock-domain-crossing channel between N_REQ local requesters. Round-robin arbitration picks a requester, and the block registers its data word and drives the crossing request. The returning asynchronous acknowledge is resynchronised through an internal STAGES-deep multi-flop synchroniser before the full handshake completes. It sits between local producers and the destination-domain receiver of a multi-bit bus synchroniser.

## Interface
- DATA_W, 8, payload width
- N_REQ, 2, number of requesters (>=1)
- STAGES, 2, flops in the ack synchroniser (>=2)
- TIMEOUT_CYC, 64, max cycles xfer_req_o waits for ack high; 0 disables timeout
- clk  in  1  single clock; all logic rising-edge
- rstn  in  1  reset, synchronous, active-low
- req_valid_i  in  N_REQ  per-requester valid
- req_data_i  in  N_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready_o  out  N_REQ  one-hot accept strobe (combinational)
- xfer_req_o  out  1  registered crossing request
- xfer_data_o  out  DATA_W  registered payload, stable while xfer_req_o=1
- xfer_src_o  out  max(1,$clog2(N_REQ))  index of the granted requester, registered with the data
- ack_async_i  in  1  acknowledge from destination domain, asynchronous
- busy_o  out  1  high whenever state != IDLE
- timeout_o  out  1  one-cycle pulse on a timeout abort

## Operation
- ack_s = last flop of a STAGES-deep chain clocked by clk that samples ack_async_i. ack_async_i is used nowhere else.
- States: IDLE, REQ_HI, REQ_LO.
- IDLE: req_ready_o = one-hot round-robin winner among req_valid_i, otherwise 0.
  - Search starts at the rr pointer and wraps.
  - On any valid: capture the winner's data into xfer_data_o, capture its index into xfer_src_o, set xfer_req_o<=1, set rr pointer<=winner+1 mod N_REQ, go to REQ_HI.
- REQ_HI: req_ready_o=0.
  - ack_s=1: xfer_req_o<=0, go to REQ_LO.
  - Else, if TIMEOUT_CYC!=0 and the counter equals TIMEOUT_CYC-1: xfer_req_o<=0, timeout_o<=1 for one cycle, go to REQ_LO.
  - Else: counter increments.
  - The counter clears on entry to REQ_HI.
- REQ_LO: wait for ack_s=0, then go to IDLE. There is no timeout in this state.
- If ack_s=1 and the timeout condition occur in the same cycle, ack wins and no timeout_o pulse is produced.
- Requesters hold valid and data until they see ready. Dropping valid before grant is legal; the requester is simply not selected.
- xfer_data_o and xfer_src_o change only on accept.

## Timing
- Reset (rstn=0 at an edge) sets:
  - state=IDLE, xfer_req_o=0, xfer_data_o=0, xfer_src_o=0
  - sync chain=0, rr pointer=0, counter=0
  - timeout_o=0, busy_o=0
  - req_ready_o is forced to 0 while rstn=0.
- Reset mid-transfer drops xfer_req_o at that edge. The destination must tolerate an aborted request.
- Accept edge E0 sets xfer_req_o=1.
- With ack_async_i looped back from xfer_req_o:
  - ack_s rises after edge E(STAGES).
  - xfer_req_o falls at E(STAGES+1).
  - state returns to IDLE at E(2*STAGES+2).
  - Next accept is at E(2*STAGES+3); with STAGES=2 that is 7 cycles accept-to-accept.
- With ack stuck low, xfer_req_o is high for exactly TIMEOUT_CYC cycles. timeout_o is high in the cycle after the falling edge of xfer_req_o is set.
- busy_o is registered from state and goes high the cycle after accept.

## Test plan
- **Reset:** hold rstn=0 for 3 cycles with all req_valid_i=1. Required: every output is 0 throughout and req_ready_o=0.
- **Single transfer:** N_REQ=2, STAGES=2, ack looped back. Requester 0 sends 0xA5. Required:
  - xfer_data_o=0xA5 and xfer_src_o=0.
  - xfer_req_o is high for 3 cycles.
  - busy_o falls 6 cycles after accept.
- **Round robin:** both valid continuously, data 0x11 and 0x22. Required: grants alternate 0,1,0,1 and accepts are spaced 7 cycles apart.
- **Timeout:** TIMEOUT_CYC=8, ack_async_i held 0. Required:
  - xfer_req_o is high for 8 cycles, then a 1-cycle timeout_o pulse.
  - busy_o stays high until ack_s reads 0, then returns to IDLE.
- **Ack/timeout race:** arrange for ack_s to rise in the same cycle the counter hits TIMEOUT_CYC-1. Required: no timeout_o pulse and a normal REQ_LO path.
- **Reset mid-transfer:** assert rstn=0 while in REQ_HI. Required: xfer_req_o=0 at the next edge, state IDLE, and the rr pointer back to 0.

Source files
------------

// File: rtl/cdc_handshake_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack clock-domain crossing among N_REQ requesters.
// The returning asynchronous acknowledge is resynchronised through a STAGES-deep flop chain.
module cdc_handshake_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned SRC_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    xfer_req_o,
  output logic [DATA_W-1:0]       xfer_data_o,
  output logic [SRC_W-1:0]        xfer_src_o,
  input  logic                    ack_async_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned IDX_W = SRC_W + 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [STAGES-1:0] sync_q, sync_d;
  logic              xfer_req_q, xfer_req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [SRC_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;

  logic              ack_s;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  rr_inc;
  logic              found_c;
  logic [SRC_W-1:0]  win_c;
  logic [N_REQ-1:0]  win_oh_c;
  logic [DATA_W-1:0] win_data_c;
  logic [N_REQ-1:0]  ready_c;

  assign sync_d = {sync_q[STAGES-2:0], ack_async_i};
  assign ack_s  = sync_q[STAGES-1];

  // First valid requester at or after the rr pointer, wrapping
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_q} + IDX_W'(k);
      if (cand >= IDX_W'(N_REQ)) cand = cand - IDX_W'(N_REQ);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found_c && req_valid_i[i] && (cand == IDX_W'(i))) begin
          found_c = 1'b1;
          win_c   = SRC_W'(i);
        end
      end
    end
  end

  always_comb begin
    win_oh_c   = '0;
    win_data_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c == SRC_W'(i)) begin
        win_oh_c[i] = found_c;
        win_data_c  = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    xfer_req_d = xfer_req_q;
    data_d     = data_q;
    src_d      = src_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    ready_c    = '0;
    rr_inc     = {1'b0, win_c} + IDX_W'(1);
    if (rr_inc >= IDX_W'(N_REQ)) rr_inc = '0;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          ready_c    = win_oh_c;
          data_d     = win_data_c;
          src_d      = win_c;
          xfer_req_d = 1'b1;
          rr_d       = SRC_W'(rr_inc);
          cnt_d      = '0;
          state_d    = REQ_HI;
        end
      end
      REQ_HI: begin
        // Ack takes priority over a coincident timeout
        if (ack_s) begin
          xfer_req_d = 1'b0;
          state_d    = REQ_LO;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          xfer_req_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = REQ_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ_LO: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      xfer_req_q <= 1'b0;
      data_q     <= '0;
      src_q      <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      xfer_req_q <= xfer_req_d;
      data_q     <= data_d;
      src_q      <= src_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready_o = rstn ? ready_c : '0;
  assign xfer_req_o  = xfer_req_q;
  assign xfer_data_o = data_q;
  assign xfer_src_o  = src_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Bench for cdc_handshake_arbiter: directed reset/transfer/round-robin/timeout/race steps,
// then random transfers checked against a transaction-level round-robin model.
module tb_cdc_handshake_arbiter;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned N_REQ       = 2;
  localparam int unsigned STAGES      = 2;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam int unsigned SRC_W       = 1;
  localparam int unsigned BUS_W       = N_REQ * DATA_W;
  localparam int LOOP_REQ  = STAGES + 1;
  localparam int LOOP_BUSY = 2 * STAGES + 2;
  localparam int NEVER     = 1000;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N_REQ-1:0]  req_valid_i;
  logic [BUS_W-1:0]  req_data_i;
  logic [N_REQ-1:0]  req_ready_o;
  logic              xfer_req_o;
  logic [DATA_W-1:0] xfer_data_o;
  logic [SRC_W-1:0]  xfer_src_o;
  logic              ack_async_i;
  logic              busy_o;
  logic              timeout_o;

  logic loop_en;
  logic ack_man;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_rr = 0;

  assign ack_async_i = loop_en ? xfer_req_o : ack_man;

  always #5 clk = ~clk;

  cdc_handshake_arbiter #(
    .DATA_W(DATA_W), .N_REQ(N_REQ), .STAGES(STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .xfer_req_o(xfer_req_o), .xfer_data_o(xfer_data_o), .xfer_src_o(xfer_src_o),
    .ack_async_i(ack_async_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid index scanning from the pointer with wrap
  function automatic int model_winner(input logic [N_REQ-1:0] v, input int rr);
    for (int k = 0; k < N_REQ; k++)
      if (v[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
    return -1;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    model_rr = 0;
  endtask

  // Follows one accepted transfer from the accept edge until busy_o drops
  task automatic measure(input int rise, input int fall,
                         input logic [DATA_W-1:0] exp_d, input logic [SRC_W-1:0] exp_s,
                         output int req_cyc, output int busy_cyc,
                         output int to_cnt, output int to_t);
    int  unstable;
    bit  done;
    req_cyc = 0; busy_cyc = -1; to_cnt = 0; to_t = -1; unstable = 0; done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      if (xfer_req_o === 1'b1) req_cyc++;
      if (timeout_o === 1'b1) begin
        to_cnt++;
        to_t = t;
      end
      if (xfer_data_o !== exp_d || xfer_src_o !== exp_s) unstable++;
      if (busy_o !== 1'b1) begin
        busy_cyc = t;
        done = 1;
      end else begin
        ack_man = (t >= rise) && (t < fall);
        tick();
      end
    end
    chk("held_stable", unstable, 0);
  endtask

  task automatic do_xfer(input string tag, input logic [N_REQ-1:0] v, input logic loop,
                         input int rise, input int fall,
                         input int exp_req, input int exp_busy, input int exp_to,
                         output int acc_cyc);
    int w, rq, bz, tc, tt;
    logic [DATA_W-1:0] d;
    loop_en = loop;
    ack_man = 1'b0;
    req_valid_i = v;
    #1;
    w = model_winner(v, model_rr);
    chk({tag, "_ready"}, req_ready_o, 32'(1 << w));
    d = req_data_i[w*DATA_W +: DATA_W];
    tick();
    acc_cyc = cyc;
    model_rr = (w + 1) % N_REQ;
    chk({tag, "_src"}, xfer_src_o, w);
    chk({tag, "_data"}, xfer_data_o, d);
    chk({tag, "_req_set"}, xfer_req_o, 1);
    measure(rise, fall, d, SRC_W'(w), rq, bz, tc, tt);
    chk({tag, "_req_cycles"}, rq, exp_req);
    chk({tag, "_busy_cycles"}, bz, exp_busy);
    chk({tag, "_timeout_pulses"}, tc, exp_to);
    if (exp_to > 0) chk({tag, "_timeout_cycle"}, tt, exp_req);
  endtask

  initial begin
    int acc, last;
    logic [N_REQ-1:0] v;

    // Reset held with all requesters valid
    rstn = 1'b0; loop_en = 1'b1; ack_man = 1'b0;
    req_valid_i = '1; req_data_i = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", req_ready_o, 0);
      chk("rst_req", xfer_req_o, 0);
      chk("rst_data", xfer_data_o, 0);
      chk("rst_src", xfer_src_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_timeout", timeout_o, 0);
    end
    rstn = 1'b1; req_valid_i = '0; model_rr = 0;

    // Single looped-back transfer from requester 0
    req_data_i = 16'h00A5;
    do_xfer("single", 2'b01, 1'b1, NEVER, NEVER, LOOP_REQ, LOOP_BUSY, 0, acc);
    chk("single_data_a5", xfer_data_o, 8'hA5);

    // Round robin with both requesters continuously valid
    do_reset();
    req_data_i = {8'h22, 8'h11};
    last = 0;
    for (int g = 0; g < 4; g++) begin
      do_xfer("rr", 2'b11, 1'b1, NEVER, NEVER, LOOP_REQ, LOOP_BUSY, 0, acc);
      chk("rr_order", xfer_src_o, g % 2);
      if (g > 0) chk("rr_spacing", acc - last, 2 * STAGES + 3);
      last = acc;
    end

    // Ack stuck low: full timeout, then immediate return through REQ_LO
    req_data_i = {8'h5C, 8'h00};
    do_xfer("timeout", 2'b10, 1'b0, NEVER, NEVER, TIMEOUT_CYC, TIMEOUT_CYC + 1, 1, acc);

    // ack_s rises in the very cycle the counter reaches its last value
    req_data_i = {8'h00, 8'h3C};
    do_xfer("race", 2'b01, 1'b0, TIMEOUT_CYC - 1 - STAGES, TIMEOUT_CYC,
            TIMEOUT_CYC, TIMEOUT_CYC + STAGES + 1, 0, acc);

    // ack_s one cycle too late: timeout fires, REQ_LO then waits for ack to drop
    req_data_i = {8'h77, 8'h00};
    do_xfer("late_ack", 2'b10, 1'b0, TIMEOUT_CYC - STAGES, TIMEOUT_CYC + 2,
            TIMEOUT_CYC, TIMEOUT_CYC + STAGES + 3, 1, acc);

    // Reset while in REQ_HI
    loop_en = 1'b1;
    req_valid_i = 2'b01; req_data_i = 16'h6699;
    tick();
    tick();
    chk("midrst_pre_req", xfer_req_o, 1);
    rstn = 1'b0;
    tick();
    chk("midrst_req", xfer_req_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", req_ready_o, 0);
    rstn = 1'b1; model_rr = 0;
    do_xfer("post_rst", 2'b11, 1'b1, NEVER, NEVER, LOOP_REQ, LOOP_BUSY, 0, acc);

    // Random valids and payloads
    for (int i = 0; i < 14; i++) begin
      v = N_REQ'($urandom_range(0, 3));
      req_data_i = BUS_W'($urandom);
      if (model_winner(v, model_rr) < 0) begin
        req_valid_i = v;
        #1;
        chk("rand_idle_ready", req_ready_o, 0);
        tick();
        chk("rand_idle_req", xfer_req_o, 0);
      end else begin
        do_xfer("rand", v, 1'b1, NEVER, NEVER, LOOP_REQ, LOOP_BUSY, 0, acc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
